seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_scan_decoder_pkg.sv | 41 ++++
 rtl/seg7_scan_decoder_if.sv | 27 ++
 rtl/seg7_pattern_decode.sv | 37 +++
 rtl/seg7_scan_decoder.sv | 133 +++++++++++++
 tb/tb_seg7_scan_decoder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_decoder_pkg.sv
// Shared 7-segment definitions: active-low segment codes, bit positions, reader FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg7_pkg;

  // Segment bit positions on the bus {DP,G,F,E,D,C,B,A}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-low glyph codes, DP bit held off (1); identical to the encoder's table
  localparam logic [7:0] SEG7_0 = 8'hC0;
  localparam logic [7:0] SEG7_1 = 8'hF9;
  localparam logic [7:0] SEG7_2 = 8'hA4;
  localparam logic [7:0] SEG7_3 = 8'hB0;
  localparam logic [7:0] SEG7_4 = 8'h99;
  localparam logic [7:0] SEG7_5 = 8'h92;
  localparam logic [7:0] SEG7_6 = 8'h82;
  localparam logic [7:0] SEG7_7 = 8'hF8;
  localparam logic [7:0] SEG7_8 = 8'h80;
  localparam logic [7:0] SEG7_9 = 8'h90;
  localparam logic [7:0] SEG7_A = 8'h88;
  localparam logic [7:0] SEG7_B = 8'h83;
  localparam logic [7:0] SEG7_C = 8'hC6;
  localparam logic [7:0] SEG7_D = 8'hA1;
  localparam logic [7:0] SEG7_E = 8'h86;
  localparam logic [7:0] SEG7_F = 8'h8E;

  // Reader FSM: blank bus, settling a pattern, pattern already taken
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT    = 2'd1,
    CAPTURED = 2'd2
  } seg7_state_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display pin bundle plus the decoded per-digit view seen by the reader.
// Latency: n/a (wires only).
// Backpressure: none; pins are sampled every cycle.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_done;
  logic                    err_pattern;
  logic                    err_anode;

  // Display side: drives the pins, observes the decoded result
  modport master (
    output seg_n, an_n,
    input  digits, dp, digit_valid, frame_done, err_pattern, err_anode
  );

  // Decoder side: samples the pins, produces the decoded result
  modport slave (
    input  seg_n, an_n,
    output digits, dp, digit_valid, frame_done, err_pattern, err_anode
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Inverse of the 7-segment encoder: 7 active-low segment bits -> {valid, hex}.
// Latency: combinational.
// Backpressure: none.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       valid_o,
  output logic [3:0] hex_o
);

  // Exact table match only; anything else (blank, partial glyph) is invalid
  always_comb begin
    valid_o = 1'b1;
    hex_o   = 4'h0;
    case (pat_i)
      SEG7_0[6:0]: hex_o = 4'h0;
      SEG7_1[6:0]: hex_o = 4'h1;
      SEG7_2[6:0]: hex_o = 4'h2;
      SEG7_3[6:0]: hex_o = 4'h3;
      SEG7_4[6:0]: hex_o = 4'h4;
      SEG7_5[6:0]: hex_o = 4'h5;
      SEG7_6[6:0]: hex_o = 4'h6;
      SEG7_7[6:0]: hex_o = 4'h7;
      SEG7_8[6:0]: hex_o = 4'h8;
      SEG7_9[6:0]: hex_o = 4'h9;
      SEG7_A[6:0]: hex_o = 4'hA;
      SEG7_B[6:0]: hex_o = 4'hB;
      SEG7_C[6:0]: hex_o = 4'hC;
      SEG7_D[6:0]: hex_o = 4'hD;
      SEG7_E[6:0]: hex_o = 4'hE;
      SEG7_F[6:0]: hex_o = 4'hF;
      default:     valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reads a multiplexed 7-seg display: waits for a stable digit pattern, decodes and stores it per digit.
// Latency: pins held from edge k update outputs/pulses at edge k+STABLE_CYCLES+2.
// Backpressure: none; observer only, pins sampled every cycle.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_decoder_if.slave   bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = NUM_DIGITS + 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  // Synchronizer pipeline; the idle bus is all-ones, so reset there
  logic [SW-1:0] sync1_q, s_q, s_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  seg7_state_e             state_q;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dp_q, digit_valid_q, seen_q;
  logic                    frame_done_q, err_pattern_q, err_anode_q;

  logic [NUM_DIGITS-1:0] an_s, sel, seen_d;
  logic [7:0]            seg_s;
  logic                  blank, changed, stable_hit, one_low;
  logic                  dec_valid;
  logic [3:0]            dec_hex;

  // Two-flop synchronizer plus a copy of the previous synchronized sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '1;
      s_q      <= '1;
      s_prev_q <= '1;
    end else begin
      sync1_q  <= {bus.an_n, bus.seg_n};
      s_q      <= sync1_q;
      s_prev_q <= s_q;
    end
  end

  // Split the synchronized sample and derive the capture qualifiers
  always_comb begin
    an_s       = s_q[SW-1:8];
    seg_s      = s_q[7:0];
    sel        = ~an_s;
    blank      = &an_s;
    changed    = (s_q != s_prev_q);
    stable_hit = !changed && (cnt_q == CNT_MAX);
    one_low    = $onehot(sel);
    seen_d     = seen_q | sel;
    cnt_d      = changed ? CW'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1));
  end

  // Stability run length, saturating so a long dwell never wraps into a second capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  seg7_pattern_decode u_decode (
    .pat_i   (seg_s[6:0]),
    .valid_o (dec_valid),
    .hex_o   (dec_hex)
  );

  // Reader FSM with registered per-digit results and one-cycle event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      digits_q      <= '0;
      dp_q          <= '0;
      digit_valid_q <= '0;
      seen_q        <= '0;
      frame_done_q  <= 1'b0;
      err_pattern_q <= 1'b0;
      err_anode_q   <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      err_pattern_q <= 1'b0;
      err_anode_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!blank) state_q <= COUNT;
        end
        COUNT: begin
          if (blank) begin
            state_q <= IDLE;
          end else if (stable_hit) begin
            state_q <= CAPTURED;
            if (one_low) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) begin
                  // An unreadable glyph keeps the last good hex but still reports its DP
                  if (dec_valid) digits_q[4*i +: 4] <= dec_hex;
                  dp_q[i]          <= ~seg_s[SEG_DP];
                  digit_valid_q[i] <= dec_valid;
                end
              end
              err_pattern_q <= !dec_valid;
              if (&seen_d) begin
                frame_done_q <= 1'b1;
                seen_q       <= '0;
              end else begin
                seen_q <= seen_d;
              end
            end else begin
              // Overlapping anodes: nothing trustworthy to store
              err_anode_q <= 1'b1;
            end
          end
        end
        CAPTURED: begin
          if (changed) state_q <= blank ? IDLE : COUNT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.digits      = digits_q;
  assign bus.dp          = dp_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_pattern = err_pattern_q;
  assign bus.err_anode   = err_anode_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: reset, capture latency, scan table, glitch, errors, mid-dwell reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_scan_decoder;

  logic clk;
  logic rst;
  logic clk_en;

  seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int n_frame  = 0;
  int n_errp   = 0;
  int n_erra   = 0;

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  seg;
    int          dwell;
    logic [15:0] e_digits;
    logic [3:0]  e_dp;
    logic [3:0]  e_valid;
    int          e_frames;
    int          e_errp;
    int          e_erra;
  } vec_t;

  vec_t tbl [13];

  // Gated clock so reset can be exercised with the clock stopped
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // Pulse counters: a pulse longer than one cycle counts more than once
  always @(negedge clk) begin
    if (!rst) begin
      n_frame += int'(bus.frame_done);
      n_errp  += int'(bus.err_pattern);
      n_erra  += int'(bus.err_anode);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] an, input logic [7:0] seg);
    bus.an_n  = an;
    bus.seg_n = seg;
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] d, input logic [3:0] p, input logic [3:0] v);
    chk({tag, ".digits"}, 32'(bus.digits), 32'(d));
    chk({tag, ".dp"}, 32'(bus.dp), 32'(p));
    chk({tag, ".valid"}, 32'(bus.digit_valid), 32'(v));
  endtask

  initial begin
    int bf, bp, ba;
    clk_en = 1'b0;
    rst    = 1'b0;
    drive(4'hF, 8'hFF);

    // Reset with no clock: outputs must clear from the async reset alone
    #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3 drive(4'($urandom), 8'($urandom));
    end
    #1;
    chk_outs("rst_noclk", 16'h0000, 4'h0, 4'h0);
    chk("rst_noclk.pulses", {29'd0, bus.frame_done, bus.err_pattern, bus.err_anode}, 32'd0);
    drive(4'hF, 8'hFF);
    #2 rst = 1'b0;
    #2 clk_en = 1'b1;

    // Blank anodes for 20 cycles with a busy segment bus: nothing happens
    for (int i = 0; i < 20; i++) begin
      bus.seg_n = 8'($urandom);
      run(1);
    end
    chk("idle.pulses", 32'(n_frame + n_errp + n_erra), 32'd0);
    chk_outs("idle", 16'h0000, 4'h0, 4'h0);

    // Capture latency: drive after edge 0, sampled at edge 1, capture at edge 7
    drive(4'b1110, 8'hA4);
    run(6);
    chk("lat.before", 32'(bus.digit_valid), 32'h0);
    run(1);
    chk_outs("lat.at", 16'h0002, 4'h0, 4'h1);
    run(3);
    chk("lat.pulses", 32'(n_frame + n_errp + n_erra), 32'd0);

    // Expected values are cumulative from the start of the table
    tbl[0]  = '{4'hE, 8'hF9, 8, 16'h0001, 4'h0, 4'h1, 0, 0, 0};
    tbl[1]  = '{4'hD, 8'hA4, 8, 16'h0021, 4'h0, 4'h3, 0, 0, 0};
    tbl[2]  = '{4'hB, 8'h30, 8, 16'h0321, 4'h4, 4'h7, 0, 0, 0};
    tbl[3]  = '{4'h7, 8'h99, 8, 16'h4321, 4'h4, 4'hF, 1, 0, 0};
    tbl[4]  = '{4'hE, 8'hF9, 8, 16'h4321, 4'h4, 4'hF, 1, 0, 0};
    tbl[5]  = '{4'hD, 8'hA4, 8, 16'h4321, 4'h4, 4'hF, 1, 0, 0};
    tbl[6]  = '{4'hB, 8'h30, 8, 16'h4321, 4'h4, 4'hF, 1, 0, 0};
    tbl[7]  = '{4'h7, 8'h99, 8, 16'h4321, 4'h4, 4'hF, 2, 0, 0};
    tbl[8]  = '{4'hD, 8'hFF, 8, 16'h4321, 4'h4, 4'hD, 2, 1, 0};
    tbl[9]  = '{4'hD, 8'h92, 3, 16'h4321, 4'h4, 4'hD, 2, 1, 0};
    tbl[10] = '{4'hD, 8'hB0, 8, 16'h4331, 4'h4, 4'hF, 2, 1, 0};
    tbl[11] = '{4'hC, 8'h99, 8, 16'h4331, 4'h4, 4'hF, 2, 1, 1};
    tbl[12] = '{4'hF, 8'hFF, 4, 16'h4331, 4'h4, 4'hF, 2, 1, 1};

    bf = n_frame; bp = n_errp; ba = n_erra;
    for (int r = 0; r < 13; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      drive(tbl[r].an, tbl[r].seg);
      run(tbl[r].dwell);
      chk_outs(tag, tbl[r].e_digits, tbl[r].e_dp, tbl[r].e_valid);
      chk({tag, ".frames"}, 32'(n_frame - bf), 32'(tbl[r].e_frames));
      chk({tag, ".errp"}, 32'(n_errp - bp), 32'(tbl[r].e_errp));
      chk({tag, ".erra"}, 32'(n_erra - ba), 32'(tbl[r].e_erra));
    end

    // Mid-dwell reset: seen holds digits 0,1 before reset; it must restart empty
    drive(4'hE, 8'hF9);
    run(8);
    drive(4'hB, 8'h30);
    run(4);
    #1 rst = 1'b1;
    #1;
    chk_outs("mid_rst", 16'h0000, 4'h0, 4'h0);
    drive(4'hF, 8'hFF);
    #1 rst = 1'b0;
    run(3);

    bf = n_frame;
    drive(4'hB, 8'h30);
    run(8);
    drive(4'h7, 8'h99);
    run(8);
    chk_outs("post_rst.23", 16'h4300, 4'h4, 4'hC);
    chk("post_rst.23.frames", 32'(n_frame - bf), 32'd0);
    drive(4'hE, 8'hF9);
    run(8);
    chk("post_rst.0.frames", 32'(n_frame - bf), 32'd0);
    drive(4'hD, 8'hA4);
    run(8);
    chk_outs("post_rst.01", 16'h4321, 4'h4, 4'hF);
    chk("post_rst.01.frames", 32'(n_frame - bf), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
